// File: rtl/reset_controller.sv
// reset_controller: source of the SoC system reset.
// Merges power-on reset, a debounced pushbutton, a software request and an
// optional watchdog into one reset that asserts asynchronously and releases
// synchronously after a minimum pulse width. Records the last reset cause.
// Optional watchdog enabled by defining WATCHDOG_EN (adds the wdt_kick port).
module reset_controller #(
  parameter int unsigned POR_CYCLES = 16,
  parameter int unsigned RST_CYCLES = 8,
  parameter int unsigned DB_CYCLES  = 50000,
  parameter int unsigned CW         = 16,
  parameter int unsigned WDT_CYCLES = 60000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  input  logic       sw_rst_req,
  output logic       sw_rst_ack,
  output logic       rst_out,
  output logic [1:0] rst_cause,
  output logic       busy
`ifdef WATCHDOG_EN
  ,
  input  logic       wdt_kick
`endif
);

  // Largest count any counter must reach; counters saturate here.
  localparam int unsigned MAX_AB     = (POR_CYCLES > RST_CYCLES) ? POR_CYCLES : RST_CYCLES;
  localparam int unsigned MAX_CD     = (DB_CYCLES > WDT_CYCLES) ? DB_CYCLES : WDT_CYCLES;
  localparam int unsigned MAX_CYCLES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam logic [CW-1:0] CNT_CEIL = CW'(MAX_CYCLES);

  localparam logic [CW-1:0] POR_LAST = CW'(POR_CYCLES - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_BTN = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;
  localparam logic [1:0] CAUSE_WDT = 2'b11;

  typedef enum logic [1:0] {
    ST_POR_HOLD = 2'd0,
    ST_RUN      = 2'd1,
    ST_ASSERT   = 2'd2,
    ST_QUIET    = 2'd3
  } state_t;

  // Saturating increment shared by all counters.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c >= CNT_CEIL) ? c : c + CW'(1);
  endfunction

  // Reset release synchronizer
  logic r_por_s1;
  logic r_por_s2;

  // Button synchronizer and debouncer
  logic          r_btn_s1;
  logic          r_btn_s2;
  logic          r_db;
  logic          r_db_q;
  logic [CW-1:0] r_db_cnt;
  logic          w_db_rise;

  // Controller state and registered outputs
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_cause;
  logic          r_ack;
  logic          r_rst_out;
  logic          r_busy;

  // Next-state values
  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_cause_nxt;
  logic          w_ack_nxt;

  // Trigger arbitration
  logic          w_trig;
  logic [1:0]    w_trig_code;
  logic          w_wdt_exp;

  // Two-flop synchronizer on the release edge of the async reset pin
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_por_s1 <= 1'b0;
      r_por_s2 <= 1'b0;
    end else begin
      r_por_s1 <= 1'b1;
      r_por_s2 <= r_por_s1;
    end
  end

  // Two-flop synchronizer for the raw pushbutton
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
    end else begin
      r_btn_s1 <= btn;
      r_btn_s2 <= r_btn_s1;
    end
  end

  // Debouncer: flip the stable state after DB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db     <= 1'b0;
      r_db_q   <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_db_q <= r_db;
      if (r_btn_s2 == r_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt >= DB_LAST) begin
        r_db     <= ~r_db;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= sat_inc(r_db_cnt);
      end
    end
  end

  assign w_db_rise = r_db & ~r_db_q;

`ifdef WATCHDOG_EN
  localparam logic [CW-1:0] WDT_LAST = CW'(WDT_CYCLES - 1);

  logic [CW-1:0] r_wdt_cnt;

  // Watchdog counter: counts only in RUN, cleared by a kick or any non-RUN state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wdt_cnt <= '0;
    end else if ((r_state != ST_RUN) || wdt_kick) begin
      r_wdt_cnt <= '0;
    end else begin
      r_wdt_cnt <= sat_inc(r_wdt_cnt);
    end
  end

  assign w_wdt_exp = (r_state == ST_RUN) && !wdt_kick && (r_wdt_cnt == WDT_LAST);
`else
  assign w_wdt_exp = 1'b0;
`endif

  // Trigger arbitration: button beats software beats watchdog
  always_comb begin
    w_trig      = 1'b1;
    w_trig_code = CAUSE_BTN;
    if (w_db_rise) begin
      w_trig_code = CAUSE_BTN;
    end else if (sw_rst_req) begin
      w_trig_code = CAUSE_SW;
    end else if (w_wdt_exp) begin
      w_trig_code = CAUSE_WDT;
    end else begin
      w_trig = 1'b0;
    end
  end

  // Controller next-state, counter, cause and acknowledge logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cause_nxt = r_cause;
    w_ack_nxt   = 1'b0;
    unique case (r_state)
      ST_POR_HOLD: begin
        if (r_por_s2) begin
          if (r_cnt >= POR_LAST) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = sat_inc(r_cnt);
          end
        end
      end
      ST_RUN: begin
        w_cnt_nxt = '0;
        if (w_trig) begin
          w_state_nxt = ST_ASSERT;
          w_cause_nxt = w_trig_code;
          w_ack_nxt   = (w_trig_code == CAUSE_SW);
        end
      end
      ST_ASSERT: begin
        if (r_cnt >= RST_LAST) begin
          w_cnt_nxt = '0;
          // A still-held button parks in QUIET so the reset does not release under it.
          if ((r_cause == CAUSE_BTN) && r_db) begin
            w_state_nxt = ST_QUIET;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_cnt_nxt = sat_inc(r_cnt);
        end
      end
      ST_QUIET: begin
        w_cnt_nxt = '0;
        if (!r_db) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_POR_HOLD;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State register and registered outputs; reset pin asserts rst_out immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_POR_HOLD;
      r_cnt     <= '0;
      r_cause   <= CAUSE_POR;
      r_ack     <= 1'b0;
      r_rst_out <= 1'b1;
      r_busy    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cause   <= w_cause_nxt;
      r_ack     <= w_ack_nxt;
      r_rst_out <= (w_state_nxt != ST_RUN);
      r_busy    <= (w_state_nxt != ST_RUN);
    end
  end

  assign sw_rst_ack = r_ack;
  assign rst_out    = r_rst_out;
  assign rst_cause  = r_cause;
  assign busy       = r_busy;

endmodule

// File: tb/tb_reset_controller.sv
// Testbench for reset_controller: directed scenarios plus a randomized phase,
// every cycle compared against a behavioural model of the reset rules.
// Define WATCHDOG_EN to also exercise the watchdog.
module tb_reset_controller;

  localparam int unsigned POR_CYCLES = 16;
  localparam int unsigned RST_CYCLES = 8;
  localparam int unsigned DB_CYCLES  = 4;
  localparam int unsigned CW         = 16;
  localparam int unsigned WDT_CYCLES = 100;
`ifdef WATCHDOG_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  localparam int PH_POR   = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_PULSE = 2;
  localparam int PH_QUIET = 3;

  logic       clk        = 1'b0;
  logic       reset      = 1'b1;
  logic       btn        = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       wdt_kick   = 1'b0;
  logic       sw_rst_ack;
  logic       rst_out;
  logic [1:0] rst_cause;
  logic       busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reset_controller #(
    .POR_CYCLES (POR_CYCLES),
    .RST_CYCLES (RST_CYCLES),
    .DB_CYCLES  (DB_CYCLES),
    .CW         (CW),
    .WDT_CYCLES (WDT_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .sw_rst_req (sw_rst_req),
    .sw_rst_ack (sw_rst_ack),
    .rst_out    (rst_out),
    .rst_cause  (rst_cause),
    .busy       (busy)
`ifdef WATCHDOG_EN
    ,
    .wdt_kick   (wdt_kick)
`endif
  );

  // Behavioural model: phase, edges since release, pulse time left,
  // watchdog age, button history and debounced view of the button.
  int         m_phase;
  int         m_edges;
  int         m_pulse_left;
  int         m_wd_age;
  int         m_db_run;
  logic       m_held;
  logic       m_db;
  logic       m_rose;
  logic       m_ack;
  logic [1:0] m_cause;
  logic       bq[$];

  task automatic model_reset();
    m_held       = 1'b1;
    m_phase      = PH_POR;
    m_edges      = 0;
    m_pulse_left = 0;
    m_wd_age     = 0;
    m_db_run     = 0;
    m_db         = 1'b0;
    m_rose       = 1'b0;
    m_ack        = 1'b0;
    m_cause      = 2'b00;
    bq.delete();
    bq.push_back(1'b0);
    bq.push_back(1'b0);
  endtask

  task automatic model_edge();
    logic s;
    logic rise;
    logic db_pre;
    int   code;
    if (m_held) return;
    rise   = m_rose;
    db_pre = m_db;
    // button seen by the debouncer is the one sampled two edges ago
    s = bq.pop_front();
    bq.push_back(btn);
    m_rose = 1'b0;
    if (s == m_db) begin
      m_db_run = 0;
    end else begin
      m_db_run++;
      if (m_db_run == int'(DB_CYCLES)) begin
        m_db     = s;
        m_db_run = 0;
        m_rose   = s;
      end
    end
    m_ack = 1'b0;
    case (m_phase)
      PH_POR: begin
        m_edges++;
        m_wd_age = 0;
        if (m_edges >= 2 + int'(POR_CYCLES)) m_phase = PH_RUN;
      end
      PH_RUN: begin
        if (rise) code = 1;
        else if (sw_rst_req) code = 2;
        else if (WDT_ON && !wdt_kick && m_wd_age == int'(WDT_CYCLES) - 1) code = 3;
        else code = 0;
        if (code != 0) begin
          m_cause      = 2'(code);
          m_ack        = (code == 2);
          m_phase      = PH_PULSE;
          m_pulse_left = int'(RST_CYCLES);
        end else if (wdt_kick) begin
          m_wd_age = 0;
        end else begin
          m_wd_age++;
        end
      end
      PH_PULSE: begin
        m_wd_age = 0;
        m_pulse_left--;
        if (m_pulse_left == 0) m_phase = (m_cause == 2'b01 && db_pre) ? PH_QUIET : PH_RUN;
      end
      default: begin
        m_wd_age = 0;
        if (!db_pre) m_phase = PH_RUN;
      end
    endcase
  endtask

  task automatic chk1(input string tag, input logic obs, input logic want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed %0b expected %0b at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed %0b expected %0b at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic check_model();
    logic in_reset;
    in_reset = (m_phase != PH_RUN);
    chk1("model_rst_out", rst_out, in_reset);
    chk1("model_busy", busy, in_reset);
    chk2("model_cause", rst_cause, m_cause);
    chk1("model_ack", sw_rst_ack, m_ack);
  endtask

  // One clock: advance the model at the edge, compare 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic wait_run(input string tag, input int limit);
    int n;
    n = 0;
    while (m_phase != PH_RUN && n < limit) begin
      tick();
      n++;
    end
    chk1(tag, rst_out, 1'b0);
  endtask

  task automatic check_por_release();
    reset  = 1'b1;
    m_held = 1'b0;
    repeat (17) tick();
    chk1("por_edge17_rst", rst_out, 1'b1);
    tick();
    chk1("por_edge18_rst", rst_out, 1'b0);
    chk1("por_edge18_busy", busy, 1'b0);
    chk2("por_cause", rst_cause, 2'b00);
  endtask

  initial begin
    int hold;

    // Power-on reset
    #1;
    reset = 1'b0;
    model_reset();
    repeat (5) tick();
    chk1("reset_rst_out", rst_out, 1'b1);
    chk1("reset_busy", busy, 1'b1);
    chk2("reset_cause", rst_cause, 2'b00);
    chk1("reset_ack", sw_rst_ack, 1'b0);
    check_por_release();

    // Software reset: one-cycle request
    repeat (3) tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    chk1("sw_ack_pulse", sw_rst_ack, 1'b1);
    chk2("sw_cause", rst_cause, 2'b10);
    chk1("sw_rst_rise", rst_out, 1'b1);
    repeat (7) begin
      tick();
      chk1("sw_rst_hold", rst_out, 1'b1);
      chk1("sw_ack_once", sw_rst_ack, 1'b0);
    end
    tick();
    chk1("sw_rst_release", rst_out, 1'b0);

    // Bouncing button never settles long enough
    for (int i = 0; i < 20; i++) begin
      btn = ((i / 2) % 2 == 0);
      tick();
      chk1("bounce_no_reset", rst_out, 1'b0);
    end
    btn = 1'b1;
    repeat (6) tick();
    chk1("press_before_debounce", rst_out, 1'b0);
    tick();
    chk1("press_reset", rst_out, 1'b1);
    chk2("press_cause", rst_cause, 2'b01);
    repeat (20) begin
      tick();
      chk1("quiet_hold", rst_out, 1'b1);
    end
    btn = 1'b0;
    repeat (6) tick();
    chk1("quiet_before_release", rst_out, 1'b1);
    tick();
    chk1("quiet_release", rst_out, 1'b0);

    // Debounced press and software request on the same edge
    repeat (3) tick();
    btn = 1'b1;
    repeat (6) tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    chk2("simul_cause", rst_cause, 2'b01);
    chk1("simul_no_ack", sw_rst_ack, 1'b0);
    chk1("simul_rst", rst_out, 1'b1);
    repeat (12) tick();
    btn = 1'b0;
    wait_run("simul_return", 40);

`ifdef WATCHDOG_EN
    // Regular kicks keep the watchdog quiet, then it expires 100 cycles after the last one
    repeat (6) begin
      wdt_kick = 1'b1;
      tick();
      wdt_kick = 1'b0;
      repeat (49) begin
        tick();
        chk1("wdt_kicked", rst_out, 1'b0);
      end
    end
    wdt_kick = 1'b1;
    tick();
    wdt_kick = 1'b0;
    repeat (99) tick();
    chk1("wdt_before_expiry", rst_out, 1'b0);
    tick();
    chk1("wdt_expiry", rst_out, 1'b1);
    chk2("wdt_cause", rst_cause, 2'b11);
    wait_run("wdt_return", 20);
`endif

    // Randomized button, software and kick activity
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        btn  = 1'($urandom_range(0, 1));
        hold = int'($urandom_range(1, 24));
      end
      hold--;
      sw_rst_req = ($urandom_range(0, 19) == 0);
      wdt_kick   = ($urandom_range(0, 59) == 0);
      tick();
    end
    btn        = 1'b0;
    sw_rst_req = 1'b0;
    wdt_kick   = 1'b0;
    wait_run("random_return", 60);

    // Reset pin pulled in the third cycle of a reset pulse
    repeat (2) tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    chk2("mid_pre_cause", rst_cause, 2'b10);
    repeat (2) tick();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk1("mid_rst_out", rst_out, 1'b1);
    chk2("mid_cause_cleared", rst_cause, 2'b00);
    chk1("mid_busy", busy, 1'b1);
    repeat (3) tick();
    check_por_release();
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute bound on the run
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
